// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl: pays out a change amount one coin or note at a time.
// It picks the largest non-empty denomination that fits the balance, does one
// valid/ready handshake with the hopper per unit, and finishes with a done or
// error pulse. All outputs come straight from flops.
module change_dispense_ctrl #(
    parameter int W       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] amount,
    input  logic         abort,
    input  logic [4:0]   hopper_empty,
    input  logic         coin_ready,
    output logic         coin_valid,
    output logic [2:0]   coin_out,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [1:0]   err_code,
    output logic [W-1:0] remaining
);

    typedef enum logic [2:0] {IDLE, SELECT, ISSUE, DONE_S, ERR_S} state_t;

    localparam logic [1:0]  ERR_UNPAY = 2'b01;
    localparam logic [1:0]  ERR_TMO   = 2'b10;
    localparam logic [1:0]  ERR_ABORT = 2'b11;
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

    // Denomination code to face value; code 0 means "no unit".
    function automatic logic [W-1:0] denom_val(input logic [2:0] code);
        case (code)
            3'd5:    denom_val = W'(500);
            3'd4:    denom_val = W'(100);
            3'd3:    denom_val = W'(50);
            3'd2:    denom_val = W'(10);
            3'd1:    denom_val = W'(5);
            default: denom_val = '0;
        endcase
    endfunction

    state_t      state, state_nxt;
    logic [1:0]  err_cause;
    logic [15:0] tmo_cnt;
    logic        sel_found;
    logic [2:0]  sel_code;
    logic        hs, tmo;

    logic        valid_nxt, busy_nxt, done_nxt, error_nxt;
    logic [2:0]  coin_nxt;
    logic [1:0]  err_nxt;

    assign hs  = (state == ISSUE) && coin_ready;
    assign tmo = (state == ISSUE) && !coin_ready && (tmo_cnt == TMO_LAST);

    // Greedy pick: scan low to high so the largest fitting, stocked unit wins.
    always_comb begin
        sel_found = 1'b0;
        sel_code  = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (!hopper_empty[i] && (remaining >= denom_val(3'(i + 1)))) begin
                sel_found = 1'b1;
                sel_code  = 3'(i + 1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort outranks both handshake exit and timeout.
    always_comb begin
        state_nxt = state;
        err_cause = 2'b00;
        case (state)
            IDLE:   if (start) state_nxt = SELECT;
            SELECT: begin
                if (abort) begin
                    state_nxt = ERR_S;
                    err_cause = ERR_ABORT;
                end else if (remaining == '0) begin
                    state_nxt = DONE_S;
                end else if (sel_found) begin
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = ERR_S;
                    err_cause = ERR_UNPAY;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_nxt = ERR_S;
                    err_cause = ERR_ABORT;
                end else if (coin_ready) begin
                    state_nxt = SELECT;
                end else if (tmo) begin
                    state_nxt = ERR_S;
                    err_cause = ERR_TMO;
                end
            end
            DONE_S:  state_nxt = IDLE;
            ERR_S:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from state_nxt.
    always_comb begin
        busy_nxt  = (state_nxt != IDLE);
        valid_nxt = (state_nxt == ISSUE);
        done_nxt  = (state_nxt == DONE_S);
        error_nxt = (state_nxt == ERR_S);
        coin_nxt  = 3'd0;
        if (state_nxt == ISSUE) coin_nxt = (state == ISSUE) ? coin_out : sel_code;
        err_nxt = err_code;
        if (state == IDLE && start) err_nxt = 2'b00;
        if (state_nxt == ERR_S)     err_nxt = err_cause;
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coin_valid <= 1'b0;
            coin_out   <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            coin_valid <= valid_nxt;
            coin_out   <= coin_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            err_code   <= err_nxt;
        end
    end

    // Balance and hopper wait counter; the subtract cannot underflow since
    // only units no larger than the balance are ever issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (state == IDLE && start) remaining <= amount;
            else if (hs)                remaining <= remaining - denom_val(coin_out);
            if (state == SELECT)                     tmo_cnt <= '0;
            else if (state == ISSUE && !coin_ready)  tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl (built with TIMEOUT=8).
module tb_change_dispense_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] amount;
    logic        abort;
    logic [4:0]  hopper_empty;
    logic        coin_ready;
    logic        coin_valid;
    logic [2:0]  coin_out;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [15:0] remaining;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] codes[$];
    int         vcyc;
    logic       saw_done, saw_err;

    change_dispense_ctrl #(.W(16), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount), .abort(abort),
        .hopper_empty(hopper_empty), .coin_ready(coin_ready), .coin_valid(coin_valid),
        .coin_out(coin_out), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present start for one edge; returns in the SELECT cycle.
    task automatic start_pay(input logic [15:0] amt);
        start  = 1'b1;
        amount = amt;
        tick();
        start  = 1'b0;
    endtask

    // Follow a payout until done/error, logging handshaken codes and valid cycles.
    task automatic run_to_end(input int budget);
        saw_done = 1'b0;
        saw_err  = 1'b0;
        vcyc     = 0;
        codes.delete();
        for (int i = 0; i < budget; i++) begin
            if (done)  begin saw_done = 1'b1; break; end
            if (error) begin saw_err  = 1'b1; break; end
            if (coin_valid) begin
                vcyc++;
                if (coin_ready) codes.push_back(coin_out);
            end
            tick();
        end
        if (!saw_done && !saw_err) chk("end_budget", 32'd0, 32'd1);
    endtask

    task automatic chk_codes(input string tag, input logic [2:0] exp[], input int n);
        chk({tag, "_n"}, 32'(codes.size()), 32'(n));
        for (int i = 0; i < n && i < codes.size(); i++)
            chk($sformatf("%s_c%0d", tag, i), 32'(codes[i]), 32'(exp[i]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] e1[] = '{3'd4, 3'd4, 3'd4, 3'd3, 3'd2, 3'd2, 3'd2, 3'd1};
        logic [2:0] e3[] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2};

        reset = 1'b0; start = 1'b0; amount = '0; abort = 1'b0;
        hopper_empty = 5'b0; coin_ready = 1'b0;
        #3;
        chk("rst_valid", 32'(coin_valid), 32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_code",  32'(coin_out),   32'd0);
        chk("rst_err",   32'(err_code),   32'd0);
        chk("rst_rem",   32'(remaining),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // 385, all full, ready tied high
        coin_ready = 1'b1;
        start_pay(16'd385);
        chk("t1_busy_sel",  32'(busy),       32'd1);
        chk("t1_valid_sel", 32'(coin_valid), 32'd0);
        run_to_end(100);
        chk("t1_done", 32'(saw_done), 32'd1);
        chk_codes("t1", e1, 8);
        chk("t1_rem", 32'(remaining), 32'd0);
        tick();
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_done_pulse", 32'(done), 32'd0);

        // zero amount
        start_pay(16'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_done_early", 32'(done), 32'd0);
        tick();
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_valid", 32'(coin_valid), 32'd0);
        tick();
        chk("t2_busy_after", 32'(busy), 32'd0);

        // 230 with the 100 hopper empty
        hopper_empty = 5'b01000;
        start_pay(16'd230);
        run_to_end(100);
        chk("t3_done", 32'(saw_done), 32'd1);
        chk_codes("t3", e3, 7);
        hopper_empty = 5'b0;
        tick();

        // 7: one 5, then unpayable 2
        start_pay(16'd7);
        run_to_end(100);
        chk("t4_err", 32'(saw_err), 32'd1);
        chk("t4_n", 32'(codes.size()), 32'd1);
        if (codes.size() > 0) chk("t4_c0", 32'(codes[0]), 32'd1);
        chk("t4_code", 32'(err_code), 32'd1);
        chk("t4_rem",  32'(remaining), 32'd2);
        tick();
        chk("t4_code_held", 32'(err_code), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);

        // timeout: ready never comes
        coin_ready = 1'b0;
        start_pay(16'd100);
        chk("t5_code_clr", 32'(err_code), 32'd0);
        run_to_end(100);
        chk("t5_err",  32'(saw_err), 32'd1);
        chk("t5_vcyc", 32'(vcyc), 32'd8);
        chk("t5_code", 32'(err_code), 32'd2);
        chk("t5_rem",  32'(remaining), 32'd100);
        tick();

        // ready in the 8th valid cycle is still accepted
        start_pay(16'd5);
        tick();
        chk("t6_valid1", 32'(coin_valid), 32'd1);
        chk("t6_coin",   32'(coin_out),   32'd1);
        repeat (7) tick();
        chk("t6_valid8", 32'(coin_valid), 32'd1);
        coin_ready = 1'b1;
        tick();
        coin_ready = 1'b0;
        chk("t6_no_err", 32'(error), 32'd0);
        chk("t6_rem",    32'(remaining), 32'd0);
        chk("t6_valid_drop", 32'(coin_valid), 32'd0);
        tick();
        chk("t6_done", 32'(done), 32'd1);
        tick();

        // abort coincident with first ready
        start_pay(16'd600);
        tick();
        chk("t7_coin", 32'(coin_out), 32'd5);
        coin_ready = 1'b1;
        abort = 1'b1;
        tick();
        coin_ready = 1'b0;
        abort = 1'b0;
        chk("t7_err",  32'(error), 32'd1);
        chk("t7_code", 32'(err_code), 32'd3);
        chk("t7_rem",  32'(remaining), 32'd100);
        chk("t7_done", 32'(done), 32'd0);
        tick();

        // abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t8_busy",  32'(busy), 32'd0);
        chk("t8_error", 32'(error), 32'd0);
        chk("t8_code",  32'(err_code), 32'd3);

        // async reset mid-ISSUE
        start_pay(16'd600);
        tick();
        chk("t9_valid", 32'(coin_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t9_valid_rst", 32'(coin_valid), 32'd0);
        chk("t9_busy_rst",  32'(busy),       32'd0);
        chk("t9_coin_rst",  32'(coin_out),   32'd0);
        chk("t9_rem_rst",   32'(remaining),  32'd0);
        chk("t9_code_rst",  32'(err_code),   32'd0);
        chk("t9_flags_rst", 32'({done, error}), 32'd0);
        reset = 1'b1;
        tick();
        chk("t9_idle", 32'(busy), 32'd0);
        chk("t9_no_pulse", 32'({done, error}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
